// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between the CPU fetch and data channels, one transaction in flight.
// Also counts grants and contention cycles for the performance counters.
module cpu_mem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr,
  input  logic        inst_req_valid,
  output logic        inst_req_ready,
  output logic [31:0] inst_rdata,
  output logic        inst_rdata_valid,
  input  logic        inst_rdata_ready,
  input  logic [31:0] data_addr,
  input  logic        data_wen,
  input  logic        data_ren,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_wstrb,
  output logic        data_req_ready,
  output logic [31:0] data_rdata,
  output logic        data_rdata_valid,
  input  logic        data_rdata_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic        mem_ren,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_req_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdata_valid,
  output logic        mem_rdata_ready,
  output logic [31:0] cnt_inst_grant,
  output logic [31:0] cnt_data_grant,
  output logic [31:0] cnt_conflict
);

  typedef enum logic [2:0] {IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D} state_e;

  state_e      state_q, state_d;
  logic        last_data_q, last_data_d;
  logic [31:0] cnt_inst_q, cnt_data_q, cnt_conf_q;
  logic        data_req;
  logic        grant_i, grant_d;
  logic        conflict;

  assign data_req = data_wen | data_ren;
  // Only one side can be accepted per cycle, so any cycle with both requesting has a loser.
  assign conflict = inst_req_valid & data_req & ~(inst_req_ready & data_req_ready);

  always_comb begin
    state_d          = state_q;
    last_data_d      = last_data_q;
    grant_i          = 1'b0;
    grant_d          = 1'b0;
    inst_req_ready   = 1'b0;
    inst_rdata       = '0;
    inst_rdata_valid = 1'b0;
    data_req_ready   = 1'b0;
    data_rdata       = '0;
    data_rdata_valid = 1'b0;
    mem_addr         = '0;
    mem_wen          = 1'b0;
    mem_ren          = 1'b0;
    mem_wdata        = '0;
    mem_wstrb        = '0;
    mem_rdata_ready  = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          // Fetch wins when alone, or on a tie under round-robin if data went last.
          if (inst_req_valid && (!data_req || (RR_EN && last_data_q))) begin
            grant_i     = 1'b1;
            state_d     = REQ_I;
            last_data_d = 1'b0;
          end else if (data_req) begin
            grant_d     = 1'b1;
            state_d     = REQ_D;
            last_data_d = 1'b1;
          end
        end
        REQ_I: begin
          mem_addr       = inst_addr;
          mem_ren        = 1'b1;
          inst_req_ready = mem_req_ready;
          if (mem_req_ready) state_d = WAIT_I;
        end
        REQ_D: begin
          mem_addr       = data_addr;
          mem_wen        = data_wen;
          mem_ren        = data_ren & ~data_wen;
          mem_wdata      = data_wdata;
          mem_wstrb      = data_wstrb;
          data_req_ready = mem_req_ready;
          if (mem_req_ready) state_d = data_wen ? IDLE : WAIT_D;
        end
        WAIT_I: begin
          mem_rdata_ready  = inst_rdata_ready;
          inst_rdata       = mem_rdata;
          inst_rdata_valid = mem_rdata_valid;
          if (mem_rdata_valid && inst_rdata_ready) state_d = IDLE;
        end
        WAIT_D: begin
          mem_rdata_ready  = data_rdata_ready;
          data_rdata       = mem_rdata;
          data_rdata_valid = mem_rdata_valid;
          if (mem_rdata_valid && data_rdata_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_data_q <= 1'b1;
      cnt_inst_q  <= '0;
      cnt_data_q  <= '0;
      cnt_conf_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      if (grant_i)  cnt_inst_q <= cnt_inst_q + 32'd1;
      if (grant_d)  cnt_data_q <= cnt_data_q + 32'd1;
      if (conflict) cnt_conf_q <= cnt_conf_q + 32'd1;
    end
  end

  assign cnt_inst_grant = cnt_inst_q;
  assign cnt_data_grant = cnt_data_q;
  assign cnt_conflict   = cnt_conf_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: one round-robin instance and one fixed-priority instance.
module tb_cpu_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  // round-robin instance
  logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        inst_req_valid, inst_req_ready, inst_rdata_valid, inst_rdata_ready;
  logic        data_wen, data_ren, data_req_ready, data_rdata_valid, data_rdata_ready;
  logic        mem_wen, mem_ren, mem_req_ready, mem_rdata_valid, mem_rdata_ready;
  logic [3:0]  data_wstrb, mem_wstrb;
  logic [31:0] cnt_inst_grant, cnt_data_grant, cnt_conflict;

  // fixed-priority instance
  logic [31:0] f_inst_addr, f_inst_rdata, f_data_addr, f_data_wdata, f_data_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
  logic        f_inst_req_valid, f_inst_req_ready, f_inst_rdata_valid, f_inst_rdata_ready;
  logic        f_data_wen, f_data_ren, f_data_req_ready, f_data_rdata_valid, f_data_rdata_ready;
  logic        f_mem_wen, f_mem_ren, f_mem_req_ready, f_mem_rdata_valid, f_mem_rdata_ready;
  logic [3:0]  f_data_wstrb, f_mem_wstrb;
  logic [31:0] f_cnt_inst_grant, f_cnt_data_grant, f_cnt_conflict;

  cpu_mem_arbiter #(.RR_EN(1'b1)) u_rr (
    .clk(clk), .rst(rst),
    .inst_addr(inst_addr), .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
    .inst_rdata(inst_rdata), .inst_rdata_valid(inst_rdata_valid), .inst_rdata_ready(inst_rdata_ready),
    .data_addr(data_addr), .data_wen(data_wen), .data_ren(data_ren), .data_wdata(data_wdata),
    .data_wstrb(data_wstrb), .data_req_ready(data_req_ready), .data_rdata(data_rdata),
    .data_rdata_valid(data_rdata_valid), .data_rdata_ready(data_rdata_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_req_ready(mem_req_ready), .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata_ready(mem_rdata_ready),
    .cnt_inst_grant(cnt_inst_grant), .cnt_data_grant(cnt_data_grant), .cnt_conflict(cnt_conflict)
  );

  cpu_mem_arbiter #(.RR_EN(1'b0)) u_fix (
    .clk(clk), .rst(rst),
    .inst_addr(f_inst_addr), .inst_req_valid(f_inst_req_valid), .inst_req_ready(f_inst_req_ready),
    .inst_rdata(f_inst_rdata), .inst_rdata_valid(f_inst_rdata_valid), .inst_rdata_ready(f_inst_rdata_ready),
    .data_addr(f_data_addr), .data_wen(f_data_wen), .data_ren(f_data_ren), .data_wdata(f_data_wdata),
    .data_wstrb(f_data_wstrb), .data_req_ready(f_data_req_ready), .data_rdata(f_data_rdata),
    .data_rdata_valid(f_data_rdata_valid), .data_rdata_ready(f_data_rdata_ready),
    .mem_addr(f_mem_addr), .mem_wen(f_mem_wen), .mem_ren(f_mem_ren), .mem_wdata(f_mem_wdata),
    .mem_wstrb(f_mem_wstrb), .mem_req_ready(f_mem_req_ready), .mem_rdata(f_mem_rdata),
    .mem_rdata_valid(f_mem_rdata_valid), .mem_rdata_ready(f_mem_rdata_ready),
    .cnt_inst_grant(f_cnt_inst_grant), .cnt_data_grant(f_cnt_data_grant), .cnt_conflict(f_cnt_conflict)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(); step();
    n_run++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0) begin n_fail++; $display("FAIL reset_mem_cmd: got ren=%b wen=%b want 0 0", mem_ren, mem_wen); end
    n_run++; if (inst_req_ready !== 1'b0 || data_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b %b want 0 0", inst_req_ready, data_req_ready); end
    rst = 1'b0;
    step();
    n_run++; if (cnt_inst_grant !== 32'd0 || cnt_data_grant !== 32'd0 || cnt_conflict !== 32'd0) begin n_fail++; $display("FAIL reset_counters: got %0d %0d %0d want 0 0 0", cnt_inst_grant, cnt_data_grant, cnt_conflict); end
    n_run++; if (inst_rdata_valid !== 1'b0 || data_rdata_valid !== 1'b0 || mem_rdata_ready !== 1'b0) begin n_fail++; $display("FAIL reset_resp: got %b %b %b want 0 0 0", inst_rdata_valid, data_rdata_valid, mem_rdata_ready); end
    n_run++; if (f_cnt_data_grant !== 32'd0 || f_mem_ren !== 1'b0) begin n_fail++; $display("FAIL reset_fix: got cnt=%0d ren=%b want 0 0", f_cnt_data_grant, f_mem_ren); end
    $display("[TB] reset transaction done");
  endtask

  task automatic test_inst_fetch;
    inst_addr = 32'h0000_0100; inst_req_valid = 1'b1; inst_rdata_ready = 1'b1;
    mem_req_ready = 1'b1; mem_rdata = 32'h0000_0013; mem_rdata_valid = 1'b1;
    #1;
    n_run++; if (mem_ren !== 1'b0) begin n_fail++; $display("FAIL fetch_c0_ren: got %b want 0", mem_ren); end
    step();
    n_run++; if (mem_ren !== 1'b1 || mem_wen !== 1'b0 || mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL fetch_c1_cmd: got ren=%b wen=%b strb=%h want 1 0 0", mem_ren, mem_wen, mem_wstrb); end
    n_run++; if (mem_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL fetch_c1_addr: got %h want 00000100", mem_addr); end
    n_run++; if (inst_req_ready !== 1'b1 || data_req_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_c1_ready: got %b %b want 1 0", inst_req_ready, data_req_ready); end
    n_run++; if (cnt_inst_grant !== 32'd1) begin n_fail++; $display("FAIL fetch_cnt: got %0d want 1", cnt_inst_grant); end
    step();
    n_run++; if (inst_rdata_valid !== 1'b1 || inst_rdata !== 32'h0000_0013) begin n_fail++; $display("FAIL fetch_c2_resp: got v=%b d=%h want 1 00000013", inst_rdata_valid, inst_rdata); end
    n_run++; if (mem_rdata_ready !== 1'b1 || data_rdata_valid !== 1'b0 || inst_req_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_c2_hs: got mrr=%b dv=%b irr=%b want 1 0 0", mem_rdata_ready, data_rdata_valid, inst_req_ready); end
    inst_req_valid = 1'b0;
    step();
    n_run++; if (inst_rdata_valid !== 1'b0 || mem_rdata_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_c3_idle: got v=%b mrr=%b want 0 0", inst_rdata_valid, mem_rdata_ready); end
    mem_rdata_valid = 1'b0;
    $display("[TB] fetch 0x100 transaction done");
  endtask

  task automatic test_store;
    int pulses = 0;
    data_addr = 32'h0000_0020; data_wdata = 32'hDEAD_BEEF; data_wstrb = 4'b0100;
    data_wen = 1'b1; mem_req_ready = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      n_run++; if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_wstrb !== 4'b0100 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h20) begin n_fail++; $display("FAIL store_hold%0d: got wen=%b ren=%b strb=%b wd=%h a=%h", k, mem_wen, mem_ren, mem_wstrb, mem_wdata, mem_addr); end
      if (data_req_ready) pulses++;
      if (k < 2) step();
    end
    mem_req_ready = 1'b1;
    #1;
    if (data_req_ready) pulses++;
    step();
    data_wen = 1'b0;
    #1;
    if (data_req_ready) pulses++;
    n_run++; if (pulses !== 1) begin n_fail++; $display("FAIL store_ready_pulses: got %0d want 1", pulses); end
    n_run++; if (mem_wen !== 1'b0 || mem_rdata_ready !== 1'b0 || data_rdata_valid !== 1'b0) begin n_fail++; $display("FAIL store_no_wait: got wen=%b mrr=%b dv=%b want 0 0 0", mem_wen, mem_rdata_ready, data_rdata_valid); end
    n_run++; if (cnt_data_grant !== 32'd1) begin n_fail++; $display("FAIL store_cnt: got %0d want 1", cnt_data_grant); end
    $display("[TB] store 0x20 transaction done");
  endtask

  task automatic test_resp_stall;
    inst_addr = 32'h0000_0104; inst_req_valid = 1'b1; inst_rdata_ready = 1'b0;
    mem_req_ready = 1'b1; mem_rdata = 32'h1234_5678; mem_rdata_valid = 1'b1;
    step(); step();
    inst_req_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_run++; if (mem_rdata_ready !== 1'b0 || inst_rdata_valid !== 1'b1) begin n_fail++; $display("FAIL stall%0d: got mrr=%b iv=%b want 0 1", k, mem_rdata_ready, inst_rdata_valid); end
      step();
    end
    inst_rdata_ready = 1'b1;
    #1;
    n_run++; if (mem_rdata_ready !== 1'b1 || inst_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL stall_release: got mrr=%b d=%h want 1 12345678", mem_rdata_ready, inst_rdata); end
    step();
    n_run++; if (inst_rdata_valid !== 1'b0 || mem_rdata_ready !== 1'b0) begin n_fail++; $display("FAIL stall_done: got iv=%b mrr=%b want 0 0", inst_rdata_valid, mem_rdata_ready); end
    n_run++; if (cnt_inst_grant !== 32'd2) begin n_fail++; $display("FAIL stall_cnt: got %0d want 2", cnt_inst_grant); end
    mem_rdata_valid = 1'b0;
    $display("[TB] stalled fetch 0x104 transaction done");
  endtask

  task automatic test_reset_in_wait;
    data_addr = 32'h0000_0040; data_ren = 1'b1; data_rdata_ready = 1'b1;
    mem_req_ready = 1'b1; mem_rdata_valid = 1'b0;
    step(); step();
    data_ren = 1'b0;
    #1;
    n_run++; if (mem_rdata_ready !== 1'b1 || data_rdata_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_wait: got mrr=%b dv=%b want 1 0", mem_rdata_ready, data_rdata_valid); end
    n_run++; if (cnt_data_grant !== 32'd2) begin n_fail++; $display("FAIL rstw_cnt_before: got %0d want 2", cnt_data_grant); end
    rst = 1'b1; mem_rdata_valid = 1'b1;
    #1;
    n_run++; if (mem_rdata_ready !== 1'b0 || data_rdata_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_drop: got mrr=%b dv=%b want 0 0", mem_rdata_ready, data_rdata_valid); end
    step();
    rst = 1'b0;
    #1;
    n_run++; if (data_rdata_valid !== 1'b0 || mem_rdata_ready !== 1'b0 || mem_ren !== 1'b0) begin n_fail++; $display("FAIL rstw_idle: got dv=%b mrr=%b ren=%b want 0 0 0", data_rdata_valid, mem_rdata_ready, mem_ren); end
    n_run++; if (cnt_inst_grant !== 32'd0 || cnt_data_grant !== 32'd0 || cnt_conflict !== 32'd0) begin n_fail++; $display("FAIL rstw_counters: got %0d %0d %0d want 0 0 0", cnt_inst_grant, cnt_data_grant, cnt_conflict); end
    step();
    n_run++; if (data_rdata_valid !== 1'b0) begin n_fail++; $display("FAIL rstw_stray: got %b want 0", data_rdata_valid); end
    mem_rdata_valid = 1'b0;
    $display("[TB] reset during load wait transaction done");
  endtask

  task automatic test_rr_conflict;
    inst_addr = 32'h0000_0200; inst_req_valid = 1'b1; data_addr = 32'h0000_0040; data_ren = 1'b1;
    inst_rdata_ready = 1'b1; data_rdata_ready = 1'b1;
    mem_req_ready = 1'b1; mem_rdata = 32'hA5A5_0001; mem_rdata_valid = 1'b1;
    step();
    n_run++; if (mem_addr !== 32'h200 || inst_req_ready !== 1'b1 || data_req_ready !== 1'b0) begin n_fail++; $display("FAIL rr_first_inst: got a=%h irr=%b drr=%b want 200 1 0", mem_addr, inst_req_ready, data_req_ready); end
    step();
    n_run++; if (inst_rdata_valid !== 1'b1 || inst_rdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL rr_inst_resp: got v=%b d=%h want 1 a5a50001", inst_rdata_valid, inst_rdata); end
    inst_addr = 32'h0000_0204;
    step(); step();
    n_run++; if (mem_addr !== 32'h40 || data_req_ready !== 1'b1 || inst_req_ready !== 1'b0 || mem_ren !== 1'b1) begin n_fail++; $display("FAIL rr_second_data: got a=%h drr=%b irr=%b ren=%b want 40 1 0 1", mem_addr, data_req_ready, inst_req_ready, mem_ren); end
    n_run++; if (cnt_inst_grant !== 32'd1 || cnt_data_grant !== 32'd1) begin n_fail++; $display("FAIL rr_pair_cnt: got %0d %0d want 1 1", cnt_inst_grant, cnt_data_grant); end
    step();
    n_run++; if (data_rdata_valid !== 1'b1 || data_rdata !== 32'hA5A5_0001 || inst_rdata_valid !== 1'b0) begin n_fail++; $display("FAIL rr_data_resp: got dv=%b d=%h iv=%b want 1 a5a50001 0", data_rdata_valid, data_rdata, inst_rdata_valid); end
    data_ren = 1'b0;
    step(); step();
    n_run++; if (mem_addr !== 32'h204 || inst_req_ready !== 1'b1 || cnt_inst_grant !== 32'd2) begin n_fail++; $display("FAIL rr_third_inst: got a=%h irr=%b cnt=%0d want 204 1 2", mem_addr, inst_req_ready, cnt_inst_grant); end
    n_run++; if (cnt_conflict !== 32'd5) begin n_fail++; $display("FAIL rr_conflict_cnt: got %0d want 5", cnt_conflict); end
    step();
    inst_req_valid = 1'b0;
    step();
    mem_rdata_valid = 1'b0;
    $display("[TB] round-robin conflict transactions done");
  endtask

  task automatic test_fixed_priority;
    f_inst_addr = 32'h0000_0300; f_inst_req_valid = 1'b1; f_data_addr = 32'h0000_0080; f_data_ren = 1'b1;
    f_inst_rdata_ready = 1'b1; f_data_rdata_ready = 1'b1;
    f_mem_req_ready = 1'b1; f_mem_rdata = 32'h0BAD_F00D; f_mem_rdata_valid = 1'b1;
    step();
    n_run++; if (f_mem_addr !== 32'h80 || f_data_req_ready !== 1'b1 || f_inst_req_ready !== 1'b0) begin n_fail++; $display("FAIL fix_first_data: got a=%h drr=%b irr=%b want 80 1 0", f_mem_addr, f_data_req_ready, f_inst_req_ready); end
    step();
    f_data_addr = 32'h0000_0084;
    step(); step();
    n_run++; if (f_mem_addr !== 32'h84 || f_data_req_ready !== 1'b1 || f_inst_req_ready !== 1'b0) begin n_fail++; $display("FAIL fix_second_data: got a=%h drr=%b irr=%b want 84 1 0", f_mem_addr, f_data_req_ready, f_inst_req_ready); end
    n_run++; if (f_cnt_data_grant !== 32'd2 || f_cnt_inst_grant !== 32'd0) begin n_fail++; $display("FAIL fix_grant_cnt: got d=%0d i=%0d want 2 0", f_cnt_data_grant, f_cnt_inst_grant); end
    step();
    f_data_ren = 1'b0;
    step(); step();
    n_run++; if (f_mem_addr !== 32'h300 || f_inst_req_ready !== 1'b1 || f_cnt_inst_grant !== 32'd1) begin n_fail++; $display("FAIL fix_inst_last: got a=%h irr=%b cnt=%0d want 300 1 1", f_mem_addr, f_inst_req_ready, f_cnt_inst_grant); end
    n_run++; if (f_cnt_conflict !== 32'd5) begin n_fail++; $display("FAIL fix_conflict_cnt: got %0d want 5", f_cnt_conflict); end
    step();
    f_inst_req_valid = 1'b0;
    step();
    f_mem_rdata_valid = 1'b0;
    $display("[TB] fixed-priority conflict transactions done");
  endtask

  initial begin
    rst = 1'b1;
    inst_addr = '0; inst_req_valid = 1'b0; inst_rdata_ready = 1'b0;
    data_addr = '0; data_wen = 1'b0; data_ren = 1'b0; data_wdata = '0; data_wstrb = '0; data_rdata_ready = 1'b0;
    mem_req_ready = 1'b0; mem_rdata = '0; mem_rdata_valid = 1'b0;
    f_inst_addr = '0; f_inst_req_valid = 1'b0; f_inst_rdata_ready = 1'b0;
    f_data_addr = '0; f_data_wen = 1'b0; f_data_ren = 1'b0; f_data_wdata = '0; f_data_wstrb = '0; f_data_rdata_ready = 1'b0;
    f_mem_req_ready = 1'b0; f_mem_rdata = '0; f_mem_rdata_valid = 1'b0;
    test_reset();
    test_inst_fetch();
    test_store();
    test_resp_stall();
    test_reset_in_wait();
    test_rr_conflict();
    test_fixed_priority();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
